// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: debounced two-beam lane FSMs driving entry/exit barriers and arbitrated car_in/car_out pulses
module parking_gate_ctrl_db #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(CYCLES + 1);
  logic r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) r_cnt <= '0;
      else if (r_cnt == CW'(CYCLES - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_deb = r_deb;
endmodule

module parking_gate_ctrl_lane #(
  parameter int TIMEOUT  = 50000,
  parameter bit HAS_FULL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_a,
  input  logic i_b,
  input  logic i_full,
  output logic o_done,
  output logic o_gate,
  output logic o_lamp,
  output logic o_fault
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, WAIT_FULL = 3'd1, OPEN = 3'd2,
                         PASS = 3'd3, CLEAR = 3'd4, FAULT = 3'd5;
  logic [2:0] r_state, w_next;
  logic [TW-1:0] r_cnt;
  logic r_gate, r_lamp, r_fault, w_done, w_busy;
  assign w_busy = (r_state == OPEN) || (r_state == PASS) || (r_state == CLEAR);
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:      if (i_a) w_next = (HAS_FULL && i_full) ? WAIT_FULL : OPEN;
      WAIT_FULL: w_next = !i_a ? IDLE : (!i_full ? OPEN : WAIT_FULL);
      OPEN:      w_next = (i_a && i_b) ? PASS : ((!i_a && !i_b) ? IDLE : OPEN);
      PASS:      w_next = (!i_a && i_b) ? CLEAR : ((i_a && !i_b) ? OPEN : PASS);
      CLEAR: begin
        w_next = (i_a && i_b) ? PASS : ((!i_a && !i_b) ? IDLE : CLEAR);
        w_done = !i_a && !i_b;
      end
      FAULT:     w_next = (!i_a && !i_b) ? IDLE : FAULT;
      default:   w_next = IDLE;
    endcase
    // a stuck crossing wins over any transition due in the same cycle
    if (w_busy && r_cnt == TW'(TIMEOUT - 1)) begin
      w_next = FAULT;
      w_done = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gate  <= 1'b0;
      r_lamp  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : (w_busy ? r_cnt + 1'b1 : r_cnt);
      r_gate  <= (w_next == OPEN) || (w_next == PASS) || (w_next == CLEAR) || (w_next == FAULT);
      r_lamp  <= w_next == WAIT_FULL;
      r_fault <= w_next == FAULT;
    end
  end
  assign o_done  = w_done;
  assign o_gate  = r_gate;
  assign o_lamp  = r_lamp;
  assign o_fault = r_fault;
endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic ent_a,
  input  logic ent_b,
  input  logic ext_a,
  input  logic ext_b,
  input  logic full,
  output logic car_in,
  output logic car_out,
  output logic gate_in_open,
  output logic gate_out_open,
  output logic full_lamp,
  output logic fault_in,
  output logic fault_out
);
  logic [3:0] w_raw, w_deb;
  logic w_in_done, w_out_done, w_in_lamp, w_out_lamp;
  logic r_car_in, r_car_out, r_pend;
  assign w_raw = {ext_b, ext_a, ent_b, ent_a};
  for (genvar i = 0; i < 4; i++) begin : g_db
    parking_gate_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .i_raw(w_raw[i]), .o_deb(w_deb[i])
    );
  end
  parking_gate_ctrl_lane #(.TIMEOUT(TIMEOUT_CYCLES), .HAS_FULL(1'b1)) u_in (
    .clk(clk), .reset(reset), .i_a(w_deb[0]), .i_b(w_deb[1]), .i_full(full),
    .o_done(w_in_done), .o_gate(gate_in_open), .o_lamp(w_in_lamp), .o_fault(fault_in)
  );
  parking_gate_ctrl_lane #(.TIMEOUT(TIMEOUT_CYCLES), .HAS_FULL(1'b0)) u_out (
    .clk(clk), .reset(reset), .i_a(w_deb[2]), .i_b(w_deb[3]), .i_full(1'b0),
    .o_done(w_out_done), .o_gate(gate_out_open), .o_lamp(w_out_lamp), .o_fault(fault_out)
  );
  assign full_lamp = w_in_lamp | w_out_lamp;
  // exit defers one cycle on a tie; neither lane can complete again that soon
  always_ff @(posedge clk) begin
    if (reset) begin
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_car_in  <= w_in_done;
      r_car_out <= (w_out_done && !w_in_done) || r_pend;
      r_pend    <= w_out_done && w_in_done;
    end
  end
  assign car_in  = r_car_in;
  assign car_out = r_car_out;
endmodule
